// File: rtl/layer_compositor.sv
// layer_compositor: merges NUM_LAYERS sprite streams by fixed index priority.
// Index 0 has the highest priority, and 12'h000 is the transparency key.
// The layer-enable mask is shadowed per frame, and a HUD band or background
// colour fills pixels where no layer is opaque. The output is scaled by a
// frame-synchronous brightness value for fade transitions.
// Latency from inputs to rgb_out / hit_valid / hit_layer is 2 cycles.
// Optional fade engine: define LAYER_COMPOSITOR_FADE_EN to build the fade FSM
// and the channel scaling. Without it, brightness is fixed at full scale.
module layer_compositor #(
    parameter int          NUM_LAYERS  = 8,
    parameter int          HUD_ROWS    = 20,
    parameter logic [11:0] HUD_COLOR   = 12'h000,
    parameter logic [11:0] BG_COLOR    = 12'hFDA,
    parameter int          FADE_FRAMES = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          frame_start,
    input  logic                          valid,
    input  logic [9:0]                    v_cnt,
    input  logic [NUM_LAYERS*12-1:0]      layer_pixels,
    input  logic [NUM_LAYERS-1:0]         layer_en,
    input  logic                          fade_req,
    output logic                          fade_busy,
    output logic                          fade_black,
    output logic [11:0]                   rgb_out,
    output logic                          hit_valid,
    output logic [$clog2(NUM_LAYERS)-1:0] hit_layer
);

    localparam int          LW         = $clog2(NUM_LAYERS);
    localparam int          PW         = NUM_LAYERS * 12;
    localparam logic [31:0] HUD_ROWS_U = 32'(HUD_ROWS);

    // Frame-shadowed enable mask
    logic [NUM_LAYERS-1:0] en_q;

    // Stage 1 registers
    logic                  s1_valid_q;
    logic [PW-1:0]         s1_pix_q;
    logic                  s1_hud_q;
    logic [NUM_LAYERS-1:0] s1_en_q;

    // Stage 2 combinational results
    logic                  win_found_s;
    logic [LW-1:0]         win_idx_s;
    logic [11:0]           win_pix_s;
    logic [11:0]           base_s;
    logic [11:0]           scaled_s;

    // Output registers
    logic [11:0]           rgb_q;
    logic                  hit_valid_q;
    logic [LW-1:0]         hit_layer_q;

    // Load the layer-enable shadow once per frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q <= '1;
        end else if (frame_start) begin
            en_q <= layer_en;
        end
    end

    // Stage 1: capture the pixels, valid, the HUD-row compare and the enable mask in force for this pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_pix_q   <= '0;
            s1_hud_q   <= 1'b0;
            s1_en_q    <= '1;
        end else begin
            s1_valid_q <= valid;
            s1_pix_q   <= layer_pixels;
            s1_hud_q   <= ({22'd0, v_cnt} < HUD_ROWS_U);
            s1_en_q    <= en_q;
        end
    end

    // Priority select: scanning downwards lets the lowest opaque index overwrite higher ones
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        win_pix_s   = 12'h000;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            win_found_s = win_found_s | (s1_en_q[i] & (s1_pix_q[12*i +: 12] != 12'h000));
            win_idx_s   = (s1_en_q[i] && (s1_pix_q[12*i +: 12] != 12'h000)) ? LW'(i) : win_idx_s;
            win_pix_s   = (s1_en_q[i] && (s1_pix_q[12*i +: 12] != 12'h000)) ? s1_pix_q[12*i +: 12] : win_pix_s;
        end
    end

    // Choose the unscaled pixel: blanking, winning layer, HUD band or background
    always_comb begin
        base_s = 12'h000;
        if (!s1_valid_q) begin
            base_s = 12'h000;
        end else if (win_found_s) begin
            base_s = win_pix_s;
        end else if (s1_hud_q) begin
            base_s = HUD_COLOR;
        end else begin
            base_s = BG_COLOR;
        end
    end

`ifdef LAYER_COMPOSITOR_FADE_EN
    localparam int            CW       = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FADE_FRAMES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OUT  = 2'd1,
        S_HOLD = 2'd2,
        S_IN   = 2'd3
    } fade_state_e;

    fade_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    b_q, b_d;
    logic          busy_q, busy_d;
    logic          black_q, black_d;
    logic [4:0]    s1_b_q;

    // Scale one 4-bit channel by brightness b/16, truncating
    function automatic logic [3:0] scale_ch(input logic [3:0] c, input logic [4:0] b);
        logic [8:0] prod;
        prod = {5'd0, c} * {4'd0, b};
        return prod[7:4];
    endfunction

    // Scale all three channels of a pixel
    function automatic logic [11:0] scale_px(input logic [11:0] px, input logic [4:0] b);
        return {scale_ch(px[11:8], b), scale_ch(px[7:4], b), scale_ch(px[3:0], b)};
    endfunction

    // Brightness travels with the pixel so a change never hits a pixel presented before it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_b_q <= 5'd16;
        end else begin
            s1_b_q <= b_q;
        end
    end

    // Apply the brightness of this pixel's stage-1 snapshot
    always_comb begin
        scaled_s = scale_px(base_s, s1_b_q);
    end

    // Fade FSM state, frame counter, brightness and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            b_q     <= 5'd16;
            busy_q  <= 1'b0;
            black_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            black_q <= black_d;
        end
    end

    // Fade next-state: brightness steps only on frame_start, every FADE_FRAMES frames
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        b_d     = b_q;
        case (state_q)
            S_IDLE: begin
                b_d = 5'd16;
                if (fade_req) begin
                    state_d = S_OUT;
                    cnt_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_OUT: begin
                if (frame_start) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        b_d   = b_q - 5'd1;
                        if (b_q == 5'd1) begin
                            state_d = S_HOLD;
                        end else begin
                            state_d = S_OUT;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    state_d = S_OUT;
                end
            end
            S_HOLD: begin
                b_d = 5'd0;
                if (frame_start) begin
                    state_d = S_IN;
                    cnt_d   = '0;
                end else begin
                    state_d = S_HOLD;
                end
            end
            S_IN: begin
                if (frame_start) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        b_d   = b_q + 5'd1;
                        if (b_q == 5'd15) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_IN;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    state_d = S_IN;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                b_d     = 5'd16;
            end
        endcase
        busy_d  = (state_d != S_IDLE);
        black_d = (state_q == S_OUT) && (state_d == S_HOLD);
    end

    assign fade_busy  = busy_q;
    assign fade_black = black_q;
`else
    logic unused_fade_req_s;

    // Without the fade engine, brightness is fixed at full scale
    always_comb begin
        scaled_s = base_s;
    end

    assign unused_fade_req_s = fade_req;
    assign fade_busy         = 1'b0;
    assign fade_black        = 1'b0;
`endif

    // Stage 2: register the composited pixel and the hit information
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q       <= 12'h000;
            hit_valid_q <= 1'b0;
            hit_layer_q <= '0;
        end else begin
            rgb_q       <= scaled_s;
            hit_valid_q <= s1_valid_q & win_found_s;
            hit_layer_q <= (s1_valid_q && win_found_s) ? win_idx_s : '0;
        end
    end

    assign rgb_out   = rgb_q;
    assign hit_valid = hit_valid_q;
    assign hit_layer = hit_layer_q;

endmodule

// File: tb/tb_layer_compositor.sv
// Self-checking bench for layer_compositor. It applies directed and random
// stimulus and compares every cycle against a frame-level reference model.
// The model is written in terms of pixel priority and the number of frames
// elapsed since a fade request.
module tb_layer_compositor;

    localparam int NL = 8;
    localparam int FF = 2;
`ifdef LAYER_COMPOSITOR_FADE_EN
    localparam bit FADE_ON = 1'b1;
`else
    localparam bit FADE_ON = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            frame_start;
    logic            valid;
    logic [9:0]      v_cnt;
    logic [NL*12-1:0] layer_pixels;
    logic [NL-1:0]   layer_en;
    logic            fade_req;
    logic            fade_busy;
    logic            fade_black;
    logic [11:0]     rgb_out;
    logic            hit_valid;
    logic [2:0]      hit_layer;

    int errors;
    int checks;
    int black_seen;

    // reference model state
    logic [NL-1:0] en_m;
    bit            act_m;
    int            k_m;
    int            b_m;
    logic          black_m;
    logic [11:0]   e_rgb;
    logic          e_hv;
    logic [2:0]    e_hl;

    layer_compositor #(
        .NUM_LAYERS (NL),
        .HUD_ROWS   (20),
        .HUD_COLOR  (12'h000),
        .BG_COLOR   (12'hFDA),
        .FADE_FRAMES(FF)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .valid       (valid),
        .v_cnt       (v_cnt),
        .layer_pixels(layer_pixels),
        .layer_en    (layer_en),
        .fade_req    (fade_req),
        .fade_busy   (fade_busy),
        .fade_black  (fade_black),
        .rgb_out     (rgb_out),
        .hit_valid   (hit_valid),
        .hit_layer   (hit_layer)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic set_layer(input int i, input logic [11:0] v);
        layer_pixels[12*i +: 12] = v;
    endtask

    // brightness after k frame_starts since an accepted fade request
    function automatic int model_b(input int k);
        if (k <= 16 * FF) return 16 - k / FF;
        return (k - 16 * FF - 1) / FF;
    endfunction

    // expected output for the inputs currently applied
    task automatic model_pix(output logic [11:0] rgb, output logic hv, output logic [2:0] hl);
        int win;
        int base;
        int r;
        win = -1;
        for (int i = 0; i < NL; i++) begin
            if (en_m[i] && layer_pixels[12*i +: 12] != 12'h000) begin
                win = i;
                break;
            end
        end
        if (!valid)        base = 0;
        else if (win >= 0) base = int'(layer_pixels[12*win +: 12]);
        else if (v_cnt < 10'd20) base = 'h000;
        else               base = 'hFDA;
        r = 0;
        for (int ch = 0; ch < 3; ch++)
            r = r | (((((base >> (4 * ch)) & 15) * b_m) / 16) << (4 * ch));
        rgb = 12'(r);
        hv  = valid && (win >= 0);
        hl  = hv ? 3'(win) : 3'd0;
    endtask

    task automatic model_reset();
        en_m    = '1;
        act_m   = 1'b0;
        k_m     = 0;
        b_m     = 16;
        black_m = 1'b0;
        e_rgb   = 12'h000;
        e_hv    = 1'b0;
        e_hl    = 3'd0;
    endtask

    // one clock cycle: predict, advance, then compare the outputs
    task automatic cyc();
        logic [11:0] nr;
        logic        nh;
        logic [2:0]  nl;
        model_pix(nr, nh, nl);
        @(posedge clk);
        if (frame_start) en_m = layer_en;
        black_m = 1'b0;
        if (FADE_ON) begin
            if (!act_m) begin
                if (fade_req) begin
                    act_m = 1'b1;
                    k_m   = 0;
                end
            end else if (frame_start) begin
                k_m++;
                if (k_m == 16 * FF) black_m = 1'b1;
                if (k_m == 32 * FF + 1) act_m = 1'b0;
            end
        end
        b_m = act_m ? model_b(k_m) : 16;
        @(negedge clk);
        chk("rgb_out", rgb_out, e_rgb);
        chk("hit_valid", 12'(hit_valid), 12'(e_hv));
        chk("hit_layer", 12'(hit_layer), 12'(e_hl));
        chk("fade_busy", 12'(fade_busy), 12'(act_m));
        chk("fade_black", 12'(fade_black), 12'(black_m));
        if (fade_black === 1'b1) black_seen++;
        e_rgb = nr;
        e_hv  = nh;
        e_hl  = nl;
    endtask

    task automatic frames(input int n, input int gap);
        for (int f = 0; f < n; f++) begin
            frame_start = 1'b1;
            cyc();
            frame_start = 1'b0;
            for (int g = 1; g < gap; g++) cyc();
        end
    endtask

    // asynchronous reset pulse between clock edges; outputs must clear at once
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_rgb", rgb_out, 12'h000);
        chk("rst_hit_valid", 12'(hit_valid), 12'h000);
        chk("rst_hit_layer", 12'(hit_layer), 12'h000);
        chk("rst_busy", 12'(fade_busy), 12'h000);
        chk("rst_black", 12'(fade_black), 12'h000);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic randomize_pixels();
        for (int i = 0; i < NL; i++)
            set_layer(i, ($urandom_range(0, 1) == 1) ? 12'($urandom_range(1, 4095)) : 12'h000);
        valid = ($urandom_range(0, 3) != 0);
        v_cnt = 10'($urandom_range(0, 40));
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        black_seen   = 0;
        rst_n        = 1'b0;
        frame_start  = 1'b0;
        valid        = 1'b1;
        v_cnt        = 10'd50;
        layer_en     = 8'hFF;
        fade_req     = 1'b0;
        layer_pixels = '0;
        set_layer(1, 12'h321);
        model_reset();
        #3;
        chk("init_rgb", rgb_out, 12'h000);
        chk("init_hit_valid", 12'(hit_valid), 12'h000);
        chk("init_hit_layer", 12'(hit_layer), 12'h000);
        chk("init_busy", 12'(fade_busy), 12'h000);
        chk("init_black", 12'(fade_black), 12'h000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // empty layers: HUD band, then background
        layer_pixels = '0;
        v_cnt = 10'd5;
        cyc(); cyc();
        chk("hud_rgb", rgb_out, 12'h000);
        chk("hud_hit", 12'(hit_valid), 12'h000);
        v_cnt = 10'd100;
        cyc(); cyc();
        chk("bg_rgb", rgb_out, 12'hFDA);
        chk("bg_hit", 12'(hit_valid), 12'h000);

        // layer 3 beats layer 5, two cycles latency
        set_layer(3, 12'h0F0);
        set_layer(5, 12'hF00);
        cyc();
        chk("lat_old", rgb_out, 12'hFDA);
        cyc();
        chk("prio_rgb", rgb_out, 12'h0F0);
        chk("prio_layer", 12'(hit_layer), 12'h003);
        chk("prio_hit", 12'(hit_valid), 12'h001);

        // mask change takes effect only from the frame_start
        layer_en = 8'hF7;
        cyc(); cyc(); cyc();
        chk("mask_hold", rgb_out, 12'h0F0);
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        cyc();
        chk("mask_edge", rgb_out, 12'h0F0);
        cyc();
        chk("mask_new_rgb", rgb_out, 12'hF00);
        chk("mask_new_layer", 12'(hit_layer), 12'h005);

        // blanking
        valid = 1'b0;
        cyc(); cyc();
        chk("blank_rgb", rgb_out, 12'h000);
        chk("blank_hit", 12'(hit_valid), 12'h000);
        valid = 1'b1;

        // random compositing with random mask updates
        for (int n = 0; n < 300; n++) begin
            randomize_pixels();
            frame_start = ($urandom_range(0, 7) == 0);
            layer_en    = 8'($urandom);
            cyc();
        end
        frame_start = 1'b0;

        // fade of a white pixel; the request coincides with a frame_start
        layer_pixels = '0;
        set_layer(0, 12'hFFF);
        valid    = 1'b1;
        v_cnt    = 10'd100;
        layer_en = 8'hFF;
        frames(1, 3);
        black_seen  = 0;
        fade_req    = 1'b1;
        frame_start = 1'b1;
        cyc();
        fade_req    = 1'b0;
        frame_start = 1'b0;
        cyc(); cyc();
        chk("fade_busy_up", 12'(fade_busy), FADE_ON ? 12'h001 : 12'h000);
        chk("fade_uncounted", rgb_out, 12'hFFF);
        frames(8 * FF, 3);
        chk("fade_half", rgb_out, FADE_ON ? 12'h777 : 12'hFFF);
        fade_req = 1'b1;
        cyc();
        fade_req = 1'b0;
        frames(8 * FF, 3);
        chk("fade_black_rgb", rgb_out, FADE_ON ? 12'h000 : 12'hFFF);
        chk("fade_black_once", 12'(black_seen), FADE_ON ? 12'h001 : 12'h000);
        frames(1, 3);
        chk("fade_hold", rgb_out, FADE_ON ? 12'h000 : 12'hFFF);
        frames(16 * FF - 1, 3);
        chk("fade_nearly", 12'(fade_busy), FADE_ON ? 12'h001 : 12'h000);
        frames(1, 3);
        chk("fade_done_rgb", rgb_out, 12'hFFF);
        chk("fade_done_busy", 12'(fade_busy), 12'h000);
        chk("fade_black_total", 12'(black_seen), FADE_ON ? 12'h001 : 12'h000);

        // second fade with random pixels, cut short by reset
        fade_req = 1'b1;
        cyc();
        fade_req = 1'b0;
        for (int f = 0; f < 20; f++) begin
            for (int c = 0; c < 3; c++) begin
                randomize_pixels();
                layer_en    = 8'($urandom);
                frame_start = (c == 0);
                cyc();
            end
        end
        frame_start = 1'b0;
        chk("mid_busy", 12'(fade_busy), FADE_ON ? 12'h001 : 12'h000);
        do_reset();

        // after reset the pixel is unscaled and the mask is all ones
        layer_pixels = '0;
        set_layer(2, 12'hABC);
        valid = 1'b1;
        v_cnt = 10'd100;
        cyc(); cyc(); cyc();
        chk("post_rst_rgb", rgb_out, 12'hABC);
        chk("post_rst_layer", 12'(hit_layer), 12'h002);
        chk("post_rst_busy", 12'(fade_busy), 12'h000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
